aer_spike_encoder: RTL and testbench

AER_SPIKE_ENCODER -- requirements
Module: aer_spike_encoder

---
 rtl/lrf_aer_pkg.sv | 41 ++++
 rtl/aer_tx_hs.sv | 47 ++++
 rtl/aer_spike_encoder.sv | 169 ++++++++++++++++
 tb/tb_aer_spike_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrf_aer_pkg.sv
// Shared AER definitions: event type codes, encoder state encoding and the
// address-width helpers used by the spike encoder and its handshake block.
package lrf_aer_pkg;

    localparam logic [1:0] AER_TYPE_SPIKE  = 2'b00;
    localparam logic [1:0] AER_TYPE_TS_END = 2'b01;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_REQ_HI = 3'd3;
    localparam logic [2:0] ST_REQ_LO = 3'd4;
    localparam logic [2:0] ST_TS_END = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SCAN   = ST_SCAN,
        S_SETUP  = ST_SETUP,
        S_REQ_HI = ST_REQ_HI,
        S_REQ_LO = ST_REQ_LO,
        S_TS_END = ST_TS_END
    } aer_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Pixel field is the concatenation of per-dimension index widths.
    function automatic int aer_pix_w(input int c, input int h, input int w);
        return $clog2(c) + $clog2(h) + $clog2(w);
    endfunction

    function automatic int aer_addr_w(input int c, input int h, input int w);
        return 2 + aer_pix_w(c, h, w);
    endfunction

endpackage

// File: rtl/aer_tx_hs.sv
// Four-phase AER transmit handshake: ACK synchronizer, REQ register and the
// SETUP / REQ_HI / REQ_LO advance conditions reported back to the encoder.
module aer_tx_hs
    import lrf_aer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ack,
    input  aer_state_e i_state,
    output logic       o_req,
    output logic       o_setup_go,
    output logic       o_hi_done,
    output logic       o_lo_done
);

    logic r_ack_meta;
    logic r_ack_sync;
    logic r_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_ack_meta <= i_ack;
            r_ack_sync <= r_ack_meta;
        end
    end

    // SETUP only launches once the previous ACK has been seen low.
    assign o_setup_go = (i_state == S_SETUP)  && !r_ack_sync;
    assign o_hi_done  = (i_state == S_REQ_HI) &&  r_ack_sync;
    assign o_lo_done  = (i_state == S_REQ_LO) && !r_ack_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= 1'b0;
        end else if (o_setup_go) begin
            r_req <= 1'b1;
        end else if (o_hi_done) begin
            r_req <= 1'b0;
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/aer_spike_encoder.sv
// Spike bitmap to AER event encoder: scans each accepted word lowest bit first
// and emits one event per spike, plus an end marker after every time step.
//
// state   | meaning
// IDLE    | ready for next spike word
// SCAN    | pick lowest set bit of latched word
// SETUP   | address driven, waiting one cycle and for ACK low
// REQ_HI  | REQ high, waiting for ACK
// REQ_LO  | REQ low, waiting for ACK release
// TS_END  | load end-of-time-step marker
module aer_spike_encoder
    import lrf_aer_pkg::*;
#(
    parameter int FM_W      = 16,
    parameter int FM_H      = 16,
    parameter int FM_C      = 3,
    parameter int WORD_W    = 16,
    parameter int TIME_STEP = 8,
    localparam int AW       = aer_addr_w(FM_C, FM_H, FM_W),
    localparam int TS_W     = clog2_min1(TIME_STEP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] SPK_WORD,
    input  logic              SPK_VALID,
    output logic              SPK_READY,
    output logic              AER_REQ,
    output logic [AW-1:0]     AER_ADDR,
    input  logic              AER_ACK,
    output logic [TS_W-1:0]   TS_CNT,
    output logic              SAMPLE_DONE,
    output logic              BUSY
);

    localparam int PW      = AW - 2;
    localparam int N_PIX   = FM_C * FM_H * FM_W;
    localparam int N_WORDS = ceil_div(N_PIX, WORD_W);
    localparam int WC_W    = clog2_min1(N_WORDS + 1);
    localparam int BIT_W   = clog2_min1(WORD_W);

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(N_WORDS);
    localparam logic [TS_W-1:0] TS_LAST = TS_W'(TIME_STEP - 1);

    aer_state_e        r_state;
    logic [WORD_W-1:0] r_word;
    logic [WC_W-1:0]   r_word_cnt;
    logic [31:0]       r_base;
    logic [AW-1:0]     r_addr;
    logic              r_marker;
    logic [TS_W-1:0]   r_ts_cnt;
    logic              r_sample_done;

    logic              w_bit_found;
    logic [BIT_W-1:0]  w_bit_idx;
    logic [31:0]       w_pix;
    logic              w_pix_ok;
    logic              w_take;
    logic              w_req;
    logic              w_setup_go;
    logic              w_hi_done;
    logic              w_lo_done;

    // Descending scan so the last hit is the lowest set bit.
    always_comb begin
        w_bit_found = 1'b0;
        w_bit_idx   = '0;
        for (int b = WORD_W - 1; b >= 0; b--) begin
            if (r_word[b]) begin
                w_bit_found = 1'b1;
                w_bit_idx   = BIT_W'(b);
            end
        end
    end

    assign w_pix    = r_base + 32'(w_bit_idx);
    assign w_pix_ok = w_pix < 32'(N_PIX);
    assign w_take   = SPK_VALID && SPK_READY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_word        <= '0;
            r_word_cnt    <= '0;
            r_base        <= '0;
            r_addr        <= '0;
            r_marker      <= 1'b0;
            r_ts_cnt      <= '0;
            r_sample_done <= 1'b0;
        end else begin
            r_sample_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_word     <= SPK_WORD;
                        r_base     <= 32'(r_word_cnt) * 32'(WORD_W);
                        r_word_cnt <= r_word_cnt + WC_W'(1);
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_bit_found) begin
                        r_word <= r_word & (r_word - WORD_W'(1));
                        // Padding bits past the last pixel are dropped silently.
                        if (w_pix_ok) begin
                            r_addr  <= {AER_TYPE_SPIKE, w_pix[PW-1:0]};
                            r_state <= S_SETUP;
                        end
                    end else if (r_word_cnt == WC_LAST) begin
                        r_word_cnt <= '0;
                        r_state    <= S_TS_END;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_TS_END: begin
                    r_addr   <= {AER_TYPE_TS_END, {PW{1'b1}}};
                    r_marker <= 1'b1;
                    r_state  <= S_SETUP;
                end
                S_SETUP: begin
                    if (w_setup_go) begin
                        r_state <= S_REQ_HI;
                    end
                end
                S_REQ_HI: begin
                    if (w_hi_done) begin
                        r_state <= S_REQ_LO;
                    end
                end
                S_REQ_LO: begin
                    if (w_lo_done) begin
                        if (r_marker) begin
                            r_marker <= 1'b0;
                            r_state  <= S_IDLE;
                            if (r_ts_cnt == TS_LAST) begin
                                r_ts_cnt      <= '0;
                                r_sample_done <= 1'b1;
                            end else begin
                                r_ts_cnt <= r_ts_cnt + TS_W'(1);
                            end
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    aer_tx_hs u_tx_hs (
        .clk        (clk),
        .rst        (rst),
        .i_ack      (AER_ACK),
        .i_state    (r_state),
        .o_req      (w_req),
        .o_setup_go (w_setup_go),
        .o_hi_done  (w_hi_done),
        .o_lo_done  (w_lo_done)
    );

    assign SPK_READY   = (r_state == S_IDLE) && !rst;
    assign AER_REQ     = w_req;
    assign AER_ADDR    = r_addr;
    assign TS_CNT      = r_ts_cnt;
    assign SAMPLE_DONE = r_sample_done;
    assign BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Bench for aer_spike_encoder: a word-level event model plus a simple core
// that acknowledges REQ edges after a programmable delay.
module tb_aer_spike_encoder;

    localparam int WORD_W    = 16;
    localparam int TIME_STEP = 8;
    localparam int N_PIX     = 768;
    localparam int N_WORDS   = 48;

    logic        clk;
    logic        rst;
    logic [15:0] SPK_WORD;
    logic        SPK_VALID;
    logic        SPK_READY;
    logic        AER_REQ;
    logic [11:0] AER_ADDR;
    logic        AER_ACK;
    logic [2:0]  TS_CNT;
    logic        SAMPLE_DONE;
    logic        BUSY;

    aer_spike_encoder #(
        .FM_W      (16),
        .FM_H      (16),
        .FM_C      (3),
        .WORD_W    (WORD_W),
        .TIME_STEP (TIME_STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .SPK_WORD    (SPK_WORD),
        .SPK_VALID   (SPK_VALID),
        .SPK_READY   (SPK_READY),
        .AER_REQ     (AER_REQ),
        .AER_ADDR    (AER_ADDR),
        .AER_ACK     (AER_ACK),
        .TS_CNT      (TS_CNT),
        .SAMPLE_DONE (SAMPLE_DONE),
        .BUSY        (BUSY)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_rise_dly = 50;
    int          ack_fall_dly = 50;
    time         t_ack_fall;
    time         t_ready;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int          m_word_idx;
    int          m_ts;
    int          m_done_pending;
    int          n_done_seen;
    logic        prev_req, prev_ack, in_hs;
    logic [11:0] prev_addr, cur_addr, e_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout, wanted event", nm);
    endtask

    function automatic logic [11:0] obs_at(input int i);
        return (i < obs_q.size()) ? obs_q[i] : 12'hEEE;
    endfunction

    // Event model: one spike per set bit (pixel = word*WORD_W + bit), marker after N_WORDS.
    task automatic model_word(input logic [15:0] w);
        for (int b = 0; b < WORD_W; b++) begin
            int pix = m_word_idx * WORD_W + b;
            if (w[b] && pix < N_PIX) exp_q.push_back(12'(pix));
        end
        m_word_idx++;
        if (m_word_idx == N_WORDS) begin
            exp_q.push_back(12'h7FF);
            m_word_idx = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_word_idx     = 0;
        m_ts           = 0;
        m_done_pending = 0;
    endtask

    initial begin
        AER_ACK = 1'b0;
        forever begin
            @(posedge AER_REQ);
            #(ack_rise_dly) AER_ACK = 1'b1;
            wait (AER_REQ == 1'b0);
            #(ack_fall_dly) AER_ACK = 1'b0;
            t_ack_fall = $time;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_req  = 1'b0;
            prev_ack  = AER_ACK;
            prev_addr = AER_ADDR;
            in_hs     = 1'b0;
        end else begin
            if (AER_REQ && !prev_req) begin
                check("ack_low_before_req", 32'(prev_ack), 32'd0);
                check("addr_setup_cycle", 32'(AER_ADDR), 32'(prev_addr));
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got 0x%0h, wanted none", AER_ADDR);
                end else begin
                    e_addr = exp_q.pop_front();
                    check("event_addr", 32'(AER_ADDR), 32'(e_addr));
                    if (e_addr == 12'h7FF) begin
                        m_ts = (m_ts + 1) % TIME_STEP;
                        if (m_ts == 0) m_done_pending++;
                    end
                end
                cur_addr = AER_ADDR;
                in_hs    = 1'b1;
                obs_q.push_back(AER_ADDR);
            end else if (in_hs) begin
                check("addr_hold", 32'(AER_ADDR), 32'(cur_addr));
            end
            if (in_hs && prev_ack && !AER_ACK) in_hs = 1'b0;
            if (SPK_READY) begin
                check("ready_req_low", 32'(AER_REQ), 32'd0);
                check("ready_no_pending", 32'(exp_q.size()), 32'd0);
                check("ready_ts_cnt", 32'(TS_CNT), 32'(m_ts));
            end
            check("busy_vs_ready", 32'(BUSY), 32'(!SPK_READY));
            if (SAMPLE_DONE) begin
                check("sample_done_due", 32'(m_done_pending > 0), 32'd1);
                if (m_done_pending > 0) m_done_pending--;
                n_done_seen++;
            end
            prev_req  = AER_REQ;
            prev_ack  = AER_ACK;
            prev_addr = AER_ADDR;
        end
    end

    task automatic send_word(input logic [15:0] w);
        int k = 0;
        @(negedge clk);
        SPK_WORD  = w;
        SPK_VALID = 1'b1;
        while (!SPK_READY && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!SPK_READY) begin
            fail_now("send_word_ready");
            SPK_VALID = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        SPK_VALID = 1'b0;
        model_word(w);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_word(16'h0000);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(SPK_READY && exp_q.size() == 0 && !AER_ACK) && k < 5000);
        if (!(SPK_READY && exp_q.size() == 0)) fail_now(nm);
        t_ready = $time;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_req"},   32'(AER_REQ),     32'd0);
        check({nm, "_addr"},  32'(AER_ADDR),    32'd0);
        check({nm, "_ready"}, 32'(SPK_READY),   32'd0);
        check({nm, "_ts"},    32'(TS_CNT),      32'd0);
        check({nm, "_done"},  32'(SAMPLE_DONE), 32'd0);
        check({nm, "_busy"},  32'(BUSY),        32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, wanted finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst       = 1'b1;
        SPK_WORD  = '0;
        SPK_VALID = 1'b0;
        n_done_seen = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        #2 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(SPK_READY), 32'd1);

        // 48 empty words: only the end marker
        obs_q.delete();
        send_zeros(N_WORDS);
        wait_idle("idle_empty_ts");
        check("empty_ts_count", 32'(obs_q.size()), 32'd1);
        check("empty_ts_marker", 32'(obs_at(0)), 32'h7FF);
        check("empty_ts_tscnt", 32'(TS_CNT), 32'd1);

        // word 0 = 0x0021: pixels 0 and 5
        obs_q.delete();
        send_word(16'h0021);
        wait_idle("idle_w0");
        check("w0_count", 32'(obs_q.size()), 32'd2);
        check("w0_ev0", 32'(obs_at(0)), 32'h000);
        check("w0_ev1", 32'(obs_at(1)), 32'h005);
        check("w0_ready_after_ack", 32'(t_ready > t_ack_fall), 32'd1);
        send_zeros(N_WORDS - 1);
        wait_idle("idle_w0_ts");
        check("w0_marker", 32'(obs_at(2)), 32'h7FF);
        check("w0_tscnt", 32'(TS_CNT), 32'd2);

        // word 47 = 0xFFFF: pixels 752..767
        obs_q.delete();
        send_zeros(N_WORDS - 1);
        send_word(16'hFFFF);
        wait_idle("idle_w47");
        check("w47_count", 32'(obs_q.size()), 32'd17);
        for (int i = 0; i < 16; i++) check("w47_ev", 32'(obs_at(i)), 32'h2F0 + 32'(i));
        check("w47_marker", 32'(obs_at(16)), 32'h7FF);
        check("w47_tscnt", 32'(TS_CNT), 32'd3);

        // slow ACK release
        ack_fall_dly = 200;
        obs_q.delete();
        send_word(16'h0003);
        send_zeros(N_WORDS - 1);
        wait_idle("idle_slow_ack");
        ack_fall_dly = 50;
        check("slow_count", 32'(obs_q.size()), 32'd3);
        check("slow_ev0", 32'(obs_at(0)), 32'h000);
        check("slow_ev1", 32'(obs_at(1)), 32'h001);
        check("slow_marker", 32'(obs_at(2)), 32'h7FF);
        check("slow_tscnt", 32'(TS_CNT), 32'd4);

        // reset while REQ waits for ACK
        send_word(16'h0100);
        k = 0;
        while (!AER_REQ && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!AER_REQ) fail_now("rst_wait_req");
        #2 rst = 1'b1;
        #1 check("req_drop_on_rst", 32'(AER_REQ), 32'd0);
        model_reset();
        @(negedge clk);
        check_reset_outputs("mid_rst");
        #2 rst = 1'b0;
        k = 0;
        while (!AER_ACK && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!AER_ACK) fail_now("rst_wait_stale_ack");
        obs_q.delete();
        send_word(16'h0001);
        wait_idle("idle_after_rst");
        check("rst_restart_count", 32'(obs_q.size()), 32'd1);
        check("rst_restart_pix0", 32'(obs_at(0)), 32'h000);
        send_zeros(N_WORDS - 1);
        wait_idle("idle_after_rst_ts");
        check("rst_ts_marker", 32'(obs_at(1)), 32'h7FF);
        check("rst_tscnt", 32'(TS_CNT), 32'd1);

        // full sample: eight time steps with word 3 bit 15 (pixel 63)
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        obs_q.delete();
        n_done_seen = 0;
        for (int ts = 0; ts < TIME_STEP; ts++) begin
            send_zeros(3);
            send_word(16'h8000);
            send_zeros(N_WORDS - 4);
            wait_idle("idle_sample");
            check("sample_tscnt", 32'(TS_CNT), 32'((ts + 1) % TIME_STEP));
            check("sample_done_cnt", 32'(n_done_seen), (ts == TIME_STEP - 1) ? 32'd1 : 32'd0);
        end
        check("sample_count", 32'(obs_q.size()), 32'd16);
        for (int i = 0; i < TIME_STEP; i++) begin
            check("sample_spike", 32'(obs_at(2 * i)), 32'h03F);
            check("sample_marker", 32'(obs_at(2 * i + 1)), 32'h7FF);
        end
        check("sample_pending", 32'(m_done_pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
